// File: rtl/cdb_arbiter_multi_pkg.sv
// rtl/cdb_arbiter_multi_pkg.sv - shared CDB entry type and source/lane constants
package cdb_arbiter_multi_pkg;

  // One completed result as broadcast on a CDB lane.
  typedef struct packed {
    logic        valid;
    logic [5:0]  pd;       // physical destination register
    logic [4:0]  rd;       // architectural destination register
    logic [3:0]  rob_idx;  // reorder buffer slot
    logic [31:0] value;    // result value
  } cdb_entry_t;

  localparam int CDB_ENTRY_W = $bits(cdb_entry_t);

  // Source indices of the default four-source configuration.
  localparam int CDB_SRC_BR  = 0;
  localparam int CDB_SRC_LSQ = 1;
  localparam int CDB_SRC_MUL = 2;
  localparam int CDB_SRC_ALU = 3;

  localparam int CDB_NUM_CDB_DEFAULT = 2;

endpackage

// File: rtl/cdb_src_fifo.sv
// rtl/cdb_src_fifo.sv - per-source result buffer with wrap-around pointers
//
// Purpose: small FIFO holding completed results of one functional unit until
// the arbiter grants them a CDB lane.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_flush        : clear all entries at the next edge (dominates push/pop)
//   i_push, i_data : enqueue i_data (caller guarantees not full)
//   i_pop          : dequeue head (caller guarantees not empty)
//   o_head         : current head entry
//   o_count        : number of stored entries
//   o_empty        : no entries stored
module cdb_src_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 48,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_head,
  output logic [CNT_W-1:0] o_count,
  output logic             o_empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  // Explicit wrap so a depth of 1 (1-bit pointer, one slot) still works.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) return '0;
    return p + 1'b1;
  endfunction

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_tail <= next_ptr(r_tail);
      if (i_pop)  r_head <= next_ptr(r_head);
      if (i_push && !i_pop)      r_count <= r_count + 1'b1;
      else if (i_pop && !i_push) r_count <= r_count - 1'b1;
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge i_clk) begin
    if (i_push && !i_flush) r_mem[r_tail] <= i_data;
  end

  assign o_head  = r_mem[r_head];
  assign o_count = r_count;
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/cdb_arbiter_multi.sv
// rtl/cdb_arbiter_multi.sv - multi-lane CDB arbiter with per-source buffers
//
// Purpose: buffers results from NUM_SRC functional units and broadcasts up to
// NUM_CDB of them per cycle. Source 0 (branch) optionally has strict priority;
// the remaining sources share lanes round-robin.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_flush        : pipeline flush; kills broadcast, clears buffers
//   i_src_valid    : per-source result valid
//   i_src_data     : per-source result entries, source i at [i*W +: W]
//   o_src_ready    : per-source buffer has space
//   o_cdb_valid    : per-lane broadcast valid
//   o_cdb_out      : per-lane broadcast entries, lane j at [j*W +: W]
//   o_cdb_src      : per-lane granted source index
module cdb_arbiter_multi
  import cdb_arbiter_multi_pkg::*;
#(
  parameter int NUM_SRC   = 4,
  parameter int NUM_CDB   = CDB_NUM_CDB_DEFAULT,
  parameter int BUF_DEPTH = 2,
  parameter int PRIO_EN   = 1
) (
  input  logic                                i_clk,
  input  logic                                i_rst_n,
  input  logic                                i_flush,
  input  logic [NUM_SRC-1:0]                  i_src_valid,
  input  logic [NUM_SRC*CDB_ENTRY_W-1:0]      i_src_data,
  output logic [NUM_SRC-1:0]                  o_src_ready,
  output logic [NUM_CDB-1:0]                  o_cdb_valid,
  output logic [NUM_CDB*CDB_ENTRY_W-1:0]      o_cdb_out,
  output logic [NUM_CDB*$clog2(NUM_SRC)-1:0]  o_cdb_src
);

  localparam int EW    = CDB_ENTRY_W;
  localparam int SRC_W = $clog2(NUM_SRC);
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam logic [SRC_W-1:0] RR_INIT = (PRIO_EN != 0) ? SRC_W'(1) : '0;

  logic [EW-1:0]    w_head  [NUM_SRC];
  logic [CNT_W-1:0] w_count [NUM_SRC];
  logic [NUM_SRC-1:0] w_empty;
  logic [NUM_SRC-1:0] w_push;
  logic [NUM_SRC-1:0] w_pop;
  logic [NUM_SRC-1:0] w_grant;

  logic [NUM_CDB-1:0]       w_cdb_valid;
  logic [NUM_CDB*EW-1:0]    w_cdb_out;
  logic [NUM_CDB*SRC_W-1:0] w_cdb_src;
  logic [SRC_W-1:0]         w_rr_next;
  logic [SRC_W-1:0]         r_rr_ptr;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    // Ready depends only on stored count, never on this cycle's grant.
    assign o_src_ready[i] = (w_count[i] != CNT_W'(BUF_DEPTH));
    assign w_push[i]      = i_src_valid[i] && o_src_ready[i] && !i_flush;
    assign w_pop[i]       = w_grant[i] && !i_flush;

    cdb_src_fifo #(
      .DEPTH (BUF_DEPTH),
      .WIDTH (EW),
      .CNT_W (CNT_W)
    ) u_fifo (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_flush (i_flush),
      .i_push  (w_push[i]),
      .i_pop   (w_pop[i]),
      .i_data  (i_src_data[i*EW +: EW]),
      .o_head  (w_head[i]),
      .o_count (w_count[i]),
      .o_empty (w_empty[i])
    );
  end

  // Lane allocation: priority source first, then a round-robin sweep from
  // r_rr_ptr. Lanes are filled contiguously from lane 0.
  always_comb begin
    int         lane;
    int         idx;
    int         nxt;
    cdb_entry_t ent;
    w_grant     = '0;
    w_cdb_valid = '0;
    w_cdb_out   = '0;
    w_cdb_src   = '0;
    w_rr_next   = r_rr_ptr;
    lane        = 0;
    idx         = 0;
    nxt         = 0;
    ent         = '0;

    if ((PRIO_EN != 0) && !w_empty[0]) begin
      ent          = cdb_entry_t'(w_head[0]);
      ent.valid    = 1'b1;
      w_grant[0]   = 1'b1;
      w_cdb_valid[0] = 1'b1;
      w_cdb_out[0 +: EW] = ent;
      lane = 1;
    end

    for (int k = 0; k < NUM_SRC; k++) begin
      idx = int'(r_rr_ptr) + k;
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      if (!((PRIO_EN != 0) && (idx == 0)) && !w_empty[idx] && (lane < NUM_CDB)) begin
        ent                          = cdb_entry_t'(w_head[idx]);
        ent.valid                    = 1'b1;
        w_grant[idx]                 = 1'b1;
        w_cdb_valid[lane]            = 1'b1;
        w_cdb_out[lane*EW +: EW]     = ent;
        w_cdb_src[lane*SRC_W +: SRC_W] = SRC_W'(idx);
        lane = lane + 1;
        // Pointer lands one past the last round-robin grant, never on the
        // priority source.
        nxt = idx + 1;
        if (nxt == NUM_SRC) nxt = 0;
        if ((PRIO_EN != 0) && (nxt == 0)) nxt = 1;
        w_rr_next = SRC_W'(nxt);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)     r_rr_ptr <= RR_INIT;
    else if (i_flush) r_rr_ptr <= RR_INIT;
    else              r_rr_ptr <= w_rr_next;
  end

  // Flush kills the broadcast in the same cycle.
  assign o_cdb_valid = i_flush ? '0 : w_cdb_valid;
  assign o_cdb_out   = i_flush ? '0 : w_cdb_out;
  assign o_cdb_src   = i_flush ? '0 : w_cdb_src;

endmodule
